input_buffer: RTL and testbench



---
 rtl/io_map_pkg.sv | 43 ++++
 rtl/key_debounce.sv | 43 ++++
 rtl/input_buffer.sv | 77 +++++++
 tb/tb_input_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: IO page map and load-format helpers shared by the memory-mapped
// IO buffers on the LSU path.
package io_map_pkg;

    localparam logic [19:0] IO_LEDR_PAGE   = 20'h10000;
    localparam logic [19:0] IO_LEDG_PAGE   = 20'h10001;
    localparam logic [19:0] IO_HEX_LO_PAGE = 20'h10002;
    localparam logic [19:0] IO_HEX_HI_PAGE = 20'h10003;
    localparam logic [19:0] IO_LCD_PAGE    = 20'h10004;
    localparam logic [19:0] IO_SW_PAGE     = 20'h10010;
    localparam logic [19:0] IO_KEY_PAGE    = 20'h10011;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Halfword select uses off[1] only; misaligned halves are not supported.
    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'b0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'b0, h};
            F3_LW:   return w;
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser for one active-low key, counter-based
// debounce to a pressed=1 level, and a one-cycle pulse on each debounced press.
module key_debounce #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_CNT_W  = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_rise
);

    logic                r_s1;
    logic                r_s2;
    logic                r_level;
    logic [DB_CNT_W-1:0] r_cnt;
    logic                w_sample;
    logic                w_diff;
    logic                w_flip;

    assign w_sample = ~r_s2;
    assign w_diff   = w_sample ^ r_level;
    // The level only moves after DB_CYCLES consecutive differing samples.
    assign w_flip   = w_diff && (r_cnt == DB_CNT_W'(DB_CYCLES - 1));
    assign o_level  = r_level;
    assign o_rise   = w_flip & w_sample;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s1    <= 1'b1;
            r_s2    <= 1'b1;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn_n;
            r_s2    <= r_s1;
            r_level <= w_flip ? w_sample : r_level;
            r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/input_buffer.sv
// input_buffer: synchronised switches, debounced keys with sticky clear-on-read
// press events, funct3-formatted load data. INPUT_BUFFER_KEY_IRQ_EN adds o_key_irq.
module input_buffer
    import io_map_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int DB_CNT_W  = 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    input  logic [31:0] i_io_addr,
    input  logic [2:0]  i_funct3,
    input  logic        f_io_rden,
`ifdef INPUT_BUFFER_KEY_IRQ_EN
    output logic        o_key_irq,
`endif
    output logic [31:0] o_io_rdata,
    output logic        o_io_hit
);

    logic [31:0] r_sw1;
    logic [31:0] r_sw2;
    logic [3:0]  r_ev;
    logic [3:0]  w_level;
    logic [3:0]  w_rise;
    logic        w_sw_sel;
    logic        w_key_sel;
    logic        w_clr;
    logic [31:0] w_word;
    logic        w_unused_addr;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .DB_CNT_W (DB_CNT_W)
        ) u_db (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_btn_n(i_io_btn[k]),
            .o_level(w_level[k]),
            .o_rise (w_rise[k])
        );
    end

    assign w_sw_sel      = i_io_addr[31:12] == IO_SW_PAGE;
    assign w_key_sel     = i_io_addr[31:12] == IO_KEY_PAGE;
    assign w_unused_addr = ^i_io_addr[11:2];
    assign o_io_hit      = w_sw_sel | w_key_sel;
    assign w_word        = w_sw_sel ? r_sw2 : w_key_sel ? {24'b0, r_ev, w_level} : 32'b0;
    assign o_io_rdata    = f_io_rden ? load_fmt(w_word, i_funct3, i_io_addr[1:0]) : 32'b0;
    assign w_clr         = f_io_rden & w_key_sel & f3_valid(i_funct3);

    // A press landing in the clearing cycle must not be lost.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sw1 <= '0;
            r_sw2 <= '0;
            r_ev  <= '0;
        end else begin
            r_sw1 <= i_io_sw;
            r_sw2 <= r_sw1;
            r_ev  <= (r_ev & {4{~w_clr}}) | w_rise;
        end
    end

`ifdef INPUT_BUFFER_KEY_IRQ_EN
    logic r_irq;
    assign o_key_irq = r_irq;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_irq <= 1'b0;
        else          r_irq <= |r_ev;
    end
`endif

endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: directed plan plus randomized traffic, every cycle compared
// against a window-based behavioural model of the switch/key read path.
module tb_input_buffer;

    localparam int DB = 4;
    localparam logic [19:0] SW_PG  = 20'h10010;
    localparam logic [19:0] KEY_PG = 20'h10011;
    localparam logic [31:0] SW_A   = 32'h1001_0000;
    localparam logic [31:0] KEY_A  = 32'h1001_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        rden;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    always #5 clk = ~clk;

    input_buffer #(.DB_CYCLES(DB), .DB_CNT_W(3)) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_io_sw   (sw),
        .i_io_btn  (btn),
        .i_io_addr (addr),
        .i_funct3  (f3),
        .f_io_rden (rden),
`ifdef INPUT_BUFFER_KEY_IRQ_EN
        .o_key_irq (irq),
`endif
        .o_io_rdata(rdata),
        .o_io_hit  (hit)
    );

`ifndef INPUT_BUFFER_KEY_IRQ_EN
    assign irq = 1'b0;
`endif

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw inputs pass through two stages; a key's level changes once the
    // last DB samples since its previous change all disagree with it.
    logic [31:0]   m_sw1, m_sw2;
    logic [3:0]    m_bt1, m_bt2;
    logic [3:0]    m_lvl, m_ev;
    logic          m_irq;
    logic [DB-1:0] hist [4];
    int            n [4];

    task automatic model_reset();
        m_sw1 = '0; m_sw2 = '0; m_bt1 = 4'hF; m_bt2 = 4'hF;
        m_lvl = '0; m_ev = '0; m_irq = 1'b0;
        for (int k = 0; k < 4; k++) begin hist[k] = '0; n[k] = 0; end
    endtask

    task automatic model_update();
        logic [3:0] rise;
        logic       clr;
        logic       p;
        if (!rst_n) begin model_reset(); return; end
        rise = '0;
        clr  = rden && addr[31:12] == KEY_PG && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        for (int k = 0; k < 4; k++) begin
            p = ~m_bt2[k];
            hist[k] = {hist[k][DB-2:0], p};
            if (n[k] < DB) n[k]++;
            if (n[k] == DB && hist[k] == {DB{~m_lvl[k]}}) begin
                m_lvl[k] = p; rise[k] = p; n[k] = 0;
            end
        end
        m_irq = |m_ev;
        m_ev  = (m_ev & ~{4{clr}}) | rise;
        m_sw2 = m_sw1; m_sw1 = sw;
        m_bt2 = m_bt1; m_bt1 = btn;
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        if (!rden) return 32'b0;
        w = addr[31:12] == SW_PG ? m_sw2 : addr[31:12] == KEY_PG ? {24'b0, m_ev, m_lvl} : 32'b0;
        b = 8'(w >> (8 * addr[1:0]));
        h = 16'(w >> (16 * addr[1]));
        case (f3)
            3'd0: return 32'($signed(b));
            3'd4: return 32'(b);
            3'd1: return 32'($signed(h));
            3'd5: return 32'(h);
            3'd2: return w;
            default: return 32'b0;
        endcase
    endfunction

    task automatic cyc(input string tag, input logic [31:0] exp, input bit dir);
        #1;
        if (dir) check(tag, rdata, exp);
        check("rdata", rdata, exp_rdata());
        check("hit", {31'b0, hit}, {31'b0, addr[31:12] == SW_PG || addr[31:12] == KEY_PG});
`ifdef INPUT_BUFFER_KEY_IRQ_EN
        check("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        cyc("", 32'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] f);
        addr = a; f3 = f; rden = 1'b1;
    endtask

    task automatic idle();
        rden = 1'b0; addr = 32'b0; f3 = 3'b0;
    endtask

    initial begin
        rst_n = 1'b0; sw = '0; btn = 4'hF;
        idle();
        model_reset();
        @(negedge clk);
        rd(KEY_A, 3'b010);
        cyc("reset_key", 32'b0, 1'b1);
        rst_n = 1'b1;

        sw = 32'h8000_00F5; idle();
        repeat (3) tick();
        rd(SW_A, 3'b010);         cyc("sw_lw", 32'h8000_00F5, 1'b1);
        rd(SW_A + 3, 3'b000);     cyc("sw_lb3", 32'hFFFF_FF80, 1'b1);
        rd(SW_A, 3'b100);         cyc("sw_lbu0", 32'h0000_00F5, 1'b1);

        idle(); btn[0] = 1'b0; repeat (2) tick();
        btn[0] = 1'b1; repeat (8) tick();
        rd(KEY_A, 3'b010);        cyc("glitch", 32'h0, 1'b1);

        idle(); btn[2] = 1'b0; repeat (10) tick();
        rd(KEY_A, 3'b010);        cyc("key2_press", 32'h44, 1'b1);
        cyc("key2_clear", 32'h04, 1'b1);
        idle(); btn[2] = 1'b1; repeat (8) tick();

        btn[3] = 1'b0; repeat (8) tick();
        btn[1] = 1'b0; repeat (5) tick();
        rd(KEY_A, 3'b010);        cyc("rise_vs_clr", 32'h88, 1'b1);
        rd(KEY_A, 3'b011);        cyc("f3_invalid", 32'h0, 1'b1);
        rd(KEY_A, 3'b010);        cyc("ev_after", 32'h2A, 1'b1);

        idle(); sw = 32'h8001_7FFF; repeat (3) tick();
        rd(SW_A + 2, 3'b001);     cyc("sw_lh2", 32'hFFFF_8001, 1'b1);
        rd(32'h1001_2000, 3'b010); cyc("unmapped", 32'h0, 1'b1);
        check("unmapped_hit", {31'b0, hit}, 32'h0);

        idle(); btn = 4'hF; repeat (8) tick();
        btn[0] = 1'b0; repeat (8) tick();
        btn[2] = 1'b0; repeat (2) tick();
        rst_n = 1'b0; model_reset(); sw = '0; btn = 4'hF;
        repeat (2) tick();
        rst_n = 1'b1;
        rd(KEY_A, 3'b010);        cyc("rst_key", 32'h0, 1'b1);
        rd(SW_A, 3'b010);         cyc("rst_sw", 32'h0, 1'b1);
        check("rst_irq", {31'b0, irq}, 32'h0);
        idle(); btn[0] = 1'b0; repeat (7) tick();
`ifdef INPUT_BUFFER_KEY_IRQ_EN
        check("irq_set", {31'b0, irq}, 32'h1);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) sw = $urandom;
            case ($urandom_range(0, 3))
                0:       addr = {SW_PG, 12'($urandom)};
                1, 2:    addr = {KEY_PG, 12'($urandom)};
                default: addr = {20'h10000 + 20'($urandom_range(0, 31)), 12'($urandom)};
            endcase
            f3   = 3'($urandom_range(0, 7));
            rden = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
